// File: rtl/y86_pkg.sv
// y86_pkg: shared register IDs, data width and register-ID type for the Y86-64 pipeline.
package y86_pkg;
    localparam int DATA_W = 64;
    typedef logic [3:0] reg_id_t;
    localparam reg_id_t RRAX  = 4'h0;
    localparam reg_id_t RRCX  = 4'h1;
    localparam reg_id_t RRDX  = 4'h2;
    localparam reg_id_t RRBX  = 4'h3;
    localparam reg_id_t RRSP  = 4'h4;
    localparam reg_id_t RRBP  = 4'h5;
    localparam reg_id_t RRSI  = 4'h6;
    localparam reg_id_t RRDI  = 4'h7;
    localparam reg_id_t RR8   = 4'h8;
    localparam reg_id_t RR9   = 4'h9;
    localparam reg_id_t RR10  = 4'hA;
    localparam reg_id_t RR11  = 4'hB;
    localparam reg_id_t RR12  = 4'hC;
    localparam reg_id_t RR13  = 4'hD;
    localparam reg_id_t RR14  = 4'hE;
    localparam reg_id_t RNONE = 4'hF;
endpackage

// File: rtl/y86_reg64.sv
// y86_reg64: one architectural register with synchronous active-low clear and load enable.
module y86_reg64 #(
    parameter int W = y86_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;
    always_ff @(posedge clk) begin
        if (!reset) data_q <= '0;
        else if (load_i) data_q <= d_i;
    end
    assign q_o = data_q;
endmodule

// File: rtl/y86_regfile.sv
// y86_regfile: Y86-64 register file, two write ports (E, M with M priority) and two
// combinational read ports with optional same-cycle bypass.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = y86_pkg::DATA_W,
    parameter int NREGS  = 15,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] rsp_dbg
);
    localparam reg_id_t NR = reg_id_t'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              we_e, we_m;

    // RNONE and any out-of-range ID fall outside NR, so they never write.
    assign we_e = reset && en && (dstE < NR);
    assign we_m = reset && en && (dstM < NR);

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic sel_e, sel_m;
        assign sel_e = we_e && (dstE == reg_id_t'(i));
        assign sel_m = we_m && (dstM == reg_id_t'(i));
        y86_reg64 #(.W(DATA_W)) u_reg (
            .clk   (clk),
            .reset (reset),
            .load_i(sel_e || sel_m),
            .d_i   (sel_m ? valM : valE),
            .q_o   (regs_q[i])
        );
    end

    function automatic logic [DATA_W-1:0] rd(input reg_id_t src);
        logic byp_m, byp_e;
        byp_m = (BYPASS != 0) && we_m && (src == dstM);
        byp_e = (BYPASS != 0) && we_e && (src == dstE);
        return byp_m ? valM : byp_e ? valE : (src < NR) ? regs_q[src] : '0;
    endfunction

    assign valA    = rd(srcA);
    assign valB    = rd(srcB);
    assign rsp_dbg = regs_q[RRSP];
endmodule

// File: tb/tb_y86_regfile.sv
// tb_y86_regfile: scoreboard bench for y86_regfile, one bypassing and one non-bypassing instance.
module tb_y86_regfile;
    logic        clk = 1'b0;
    logic        reset, en;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB, rsp_dbg, valA_nb, valB_nb, rsp_nb;

    always #5 clk = ~clk;

    y86_regfile #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .en(en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB), .rsp_dbg(rsp_dbg)
    );
    y86_regfile #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .en(en), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(valA_nb), .valB(valB_nb), .rsp_dbg(rsp_nb)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = exp;
        sb.push_back(x);
    endtask

    // sel: 0 valA, 1 valB, 2 rsp_dbg, 3 valA without bypass
    task automatic drain();
        exp_t        x;
        logic [63:0] got;
        #1;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            got = x.sel == 0 ? valA : x.sel == 1 ? valB : x.sel == 2 ? rsp_dbg : valA_nb;
            check(x.tag, got, x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en   = 1'b0;
        dstE = 4'hF;
        dstM = 4'hF;
    endtask

    task automatic wr(input logic [3:0] id, input logic [63:0] v);
        en   = 1'b1;
        dstE = id;
        valE = v;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        valE = '0;
        valM = '0;
        srcA = 4'hF;
        srcB = 4'hF;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) wr(4'(i), 64'hDEAD);
        srcA = 4'h0;
        srcB = 4'hE;
        push("fill_a", 0, 64'hDEAD);
        push("fill_b", 1, 64'hDEAD);
        push("fill_rsp", 2, 64'hDEAD);
        drain();
        reset = 1'b0;
        en    = 1'b1;
        dstE  = 4'h1;
        valE  = 64'h1234;
        tick();
        reset = 1'b1;
        idle();
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i);
            srcB = 4'(14 - i);
            push($sformatf("rst_a%0d", i), 0, 64'h0);
            push($sformatf("rst_b%0d", 14 - i), 1, 64'h0);
            drain();
        end
        push("rst_rsp", 2, 64'h0);
        drain();

        en   = 1'b1;
        dstE = 4'h1;
        valE = 64'h11;
        dstM = 4'h2;
        valM = 64'h22;
        srcA = 4'h1;
        srcB = 4'h2;
        push("dual_byp_a", 0, 64'h11);
        push("dual_byp_b", 1, 64'h22);
        push("dual_nb_a", 3, 64'h0);
        drain();
        tick();
        idle();
        push("dual_a", 0, 64'h11);
        push("dual_b", 1, 64'h22);
        drain();

        en   = 1'b1;
        dstE = 4'h4;
        valE = 64'h100;
        dstM = 4'h4;
        valM = 64'h200;
        srcA = 4'h4;
        push("coll_byp_a", 0, 64'h200);
        push("coll_nb_a", 3, 64'h0);
        drain();
        tick();
        idle();
        push("coll_rsp", 2, 64'h200);
        push("coll_a", 0, 64'h200);
        push("coll_nb_after", 3, 64'h200);
        drain();

        wr(4'h3, 64'h5);
        en   = 1'b1;
        dstE = 4'h3;
        valE = 64'h9;
        srcA = 4'h3;
        push("byp_a", 0, 64'h9);
        push("nobyp_a", 3, 64'h5);
        drain();
        tick();
        idle();
        push("byp_after", 0, 64'h9);
        push("nobyp_after", 3, 64'h9);
        drain();

        en   = 1'b1;
        dstE = 4'h8;
        valE = 64'h88;
        dstM = 4'h9;
        valM = 64'h99;
        srcA = 4'h9;
        srcB = 4'h8;
        push("split_byp_a", 0, 64'h99);
        push("split_byp_b", 1, 64'h88);
        drain();
        tick();
        idle();
        srcB = 4'h9;
        push("same_src_a", 0, 64'h99);
        push("same_src_b", 1, 64'h99);
        drain();

        wr(4'h7, 64'h70);
        en   = 1'b0;
        dstE = 4'h7;
        valE = 64'hAB;
        srcA = 4'h7;
        push("stall_comb", 0, 64'h70);
        drain();
        tick();
        idle();
        push("stall_after", 0, 64'h70);
        drain();

        en   = 1'b1;
        dstE = 4'hF;
        valE = 64'hFFFF;
        srcA = 4'h1;
        srcB = 4'h2;
        tick();
        idle();
        push("none_a", 0, 64'h11);
        push("none_b", 1, 64'h22);
        drain();
        srcA = 4'hF;
        push("src_none", 0, 64'h0);
        push("src_none_nb", 3, 64'h0);
        drain();

        wr(4'h5, 64'h77);
        srcA  = 4'h5;
        reset = 1'b0;
        en    = 1'b1;
        dstM  = 4'h5;
        valM  = 64'h55;
        push("rstwr_comb", 0, 64'h77);
        drain();
        tick();
        reset = 1'b1;
        idle();
        push("rstwr_after", 0, 64'h0);
        push("rstwr_rsp", 2, 64'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
